// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: operand-forward
// selects and controller FSM state codes.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG    = 2'b00,
    FWD_EXMEM  = 2'b01,
    FWD_WB_ALU = 2'b10,
    FWD_WB_MEM = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    PCTRL_RUN      = 2'b00,
    PCTRL_MDU_BUSY = 2'b01,
    PCTRL_MEM_WAIT = 2'b10
  } pctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// Combinational operand-select for one EX source register; the youngest
// producer (EX/MEM) wins over MEM/WB.
module forward_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs_addr,
  input  logic       ex_mem_valid,
  input  logic [4:0] ex_mem_rd_addr,
  input  logic       ex_mem_reg_write,
  input  logic       mem_wb_valid,
  input  logic [4:0] mem_wb_rd_addr,
  input  logic       mem_wb_reg_write,
  input  logic       mem_wb_mem_to_reg,
  output logic [1:0] fwd_sel
);

  logic ex_mem_hit;
  logic mem_wb_hit;

  assign ex_mem_hit = ex_mem_valid && ex_mem_reg_write &&
                      (ex_mem_rd_addr != 5'd0) && (ex_mem_rd_addr == rs_addr);
  assign mem_wb_hit = mem_wb_valid && mem_wb_reg_write &&
                      (mem_wb_rd_addr != 5'd0) && (mem_wb_rd_addr == rs_addr);

  always_comb begin
    fwd_sel = FWD_REG;
    if (ex_mem_hit) begin
      fwd_sel = FWD_EXMEM;
    end else if (mem_wb_hit) begin
      fwd_sel = mem_wb_mem_to_reg ? FWD_WB_MEM : FWD_WB_ALU;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller for the 5-stage RV32 pipeline:
// forwarding, load-use, branch flush, MDU handshake and dmem wait states.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MDU_MAX_CYCLES = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs1_addr,
  input  logic [4:0]           id_rs2_addr,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 id_ex_valid,
  input  logic [4:0]           id_ex_rs1_addr,
  input  logic [4:0]           id_ex_rs2_addr,
  input  logic [4:0]           id_ex_rd_addr,
  input  logic                 id_ex_mem_read,
  input  logic                 id_ex_is_mdu,
  input  logic                 ex_mem_valid,
  input  logic [4:0]           ex_mem_rd_addr,
  input  logic                 ex_mem_reg_write,
  input  logic                 mem_wb_valid,
  input  logic [4:0]           mem_wb_rd_addr,
  input  logic                 mem_wb_reg_write,
  input  logic                 mem_wb_mem_to_reg,
  input  logic                 branch_taken,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  input  logic                 mdu_done,
  output logic [1:0]           forward_a,
  output logic [1:0]           forward_b,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 stall_mem,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 bubble_mem,
  output logic                 pc_sel_branch,
  output logic                 mdu_start,
  output logic                 mdu_error,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int MCW = $clog2(MDU_MAX_CYCLES + 1);
  localparam logic [MCW-1:0] MDU_LAST = MCW'(MDU_MAX_CYCLES - 1);

  logic [4:0] rs_addr [2];
  logic [1:0] fwd_sel [2];

  assign rs_addr[0] = id_ex_rs1_addr;
  assign rs_addr[1] = id_ex_rs2_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    forward_unit u_fwd (
      .rs_addr          (rs_addr[gi]),
      .ex_mem_valid     (ex_mem_valid),
      .ex_mem_rd_addr   (ex_mem_rd_addr),
      .ex_mem_reg_write (ex_mem_reg_write),
      .mem_wb_valid     (mem_wb_valid),
      .mem_wb_rd_addr   (mem_wb_rd_addr),
      .mem_wb_reg_write (mem_wb_reg_write),
      .mem_wb_mem_to_reg(mem_wb_mem_to_reg),
      .fwd_sel          (fwd_sel[gi])
    );
  end

  assign forward_a = fwd_sel[0];
  assign forward_b = fwd_sel[1];

  pctrl_state_e           state_reg, state_next;
  logic [MCW-1:0]         mdu_cnt_reg;
  logic                   mdu_error_reg;
  logic [CNT_WIDTH-1:0]   stall_cycles_reg;

  logic mem_block;
  logic mdu_launch;
  logic load_use;
  logic mdu_timeout;

  assign mem_block   = dmem_req && !dmem_ready;
  assign mdu_launch  = id_ex_valid && id_ex_is_mdu;
  assign load_use    = id_ex_valid && id_ex_mem_read && (id_ex_rd_addr != 5'd0) &&
                       ((id_uses_rs1 && (id_ex_rd_addr == id_rs1_addr)) ||
                        (id_uses_rs2 && (id_ex_rd_addr == id_rs2_addr)));
  // Fires on the last allowed busy cycle, so the error lands after exactly MDU_MAX_CYCLES.
  assign mdu_timeout = (state_reg == PCTRL_MDU_BUSY) && !mdu_done && (mdu_cnt_reg == MDU_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= PCTRL_RUN;
      mdu_cnt_reg      <= '0;
      mdu_error_reg    <= 1'b0;
      stall_cycles_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == PCTRL_RUN) begin
        mdu_cnt_reg <= '0;
      end else if (state_reg == PCTRL_MDU_BUSY && !mdu_timeout) begin
        mdu_cnt_reg <= mdu_cnt_reg + 1'b1;
      end
      if (mdu_timeout) begin
        mdu_error_reg <= 1'b1;
      end
      if (stall_if && (stall_cycles_reg != '1)) begin
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PCTRL_RUN: begin
        if (mem_block) begin
          state_next = PCTRL_MEM_WAIT;
        end else if (mdu_launch) begin
          state_next = PCTRL_MDU_BUSY;
        end
      end
      PCTRL_MDU_BUSY: begin
        if (mdu_done || mdu_timeout) begin
          state_next = PCTRL_RUN;
        end
      end
      PCTRL_MEM_WAIT: begin
        if (dmem_ready) begin
          state_next = PCTRL_RUN;
        end
      end
      default: state_next = PCTRL_RUN;
    endcase
  end

  always_comb begin
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    stall_ex      = 1'b0;
    stall_mem     = 1'b0;
    flush_id      = 1'b0;
    flush_ex      = 1'b0;
    bubble_mem    = 1'b0;
    pc_sel_branch = 1'b0;
    mdu_start     = 1'b0;
    case (state_reg)
      PCTRL_RUN: begin
        if (mem_block) begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
        end else if (mdu_launch) begin
          mdu_start = 1'b1;
          {stall_if, stall_id, stall_ex, bubble_mem} = 4'b1111;
        end else if (branch_taken && id_ex_valid) begin
          {pc_sel_branch, flush_id, flush_ex} = 3'b111;
        end else if (load_use) begin
          {stall_if, stall_id, flush_ex} = 3'b111;
        end
      end
      PCTRL_MDU_BUSY: begin
        // On mdu_done everything releases so EX/MEM captures the MDU result.
        if (!mdu_done) begin
          {stall_if, stall_id, stall_ex, bubble_mem} = 4'b1111;
        end
        stall_mem = mem_block;
      end
      PCTRL_MEM_WAIT: begin
        if (!dmem_ready) begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
        end
      end
      default: ;
    endcase
  end

  assign mdu_error    = mdu_error_reg;
  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed + randomized checks of pipeline_ctrl against a behavioural model
// of the hazard rules (mode flags and elapsed-cycle counts).
module tb_pipeline_ctrl;

  localparam int MAXC = 8;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr;
  logic [4:0] ex_mem_rd_addr, mem_wb_rd_addr;
  logic id_uses_rs1, id_uses_rs2, id_ex_valid, id_ex_mem_read, id_ex_is_mdu;
  logic ex_mem_valid, ex_mem_reg_write, mem_wb_valid, mem_wb_reg_write, mem_wb_mem_to_reg;
  logic branch_taken, dmem_req, dmem_ready, mdu_done;
  logic [1:0] forward_a, forward_b;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_mem;
  logic pc_sel_branch, mdu_start, mdu_error;
  logic [CW-1:0] stall_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit m_memwait;
  int m_mdu_elapsed;   // -1 when no MDU op is in flight
  bit m_err;
  int m_cnt;
  logic [8:0] e_ctrl;
  logic [1:0] e_fa, e_fb;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MDU_MAX_CYCLES(MAXC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_valid(id_ex_valid), .id_ex_rs1_addr(id_ex_rs1_addr),
    .id_ex_rs2_addr(id_ex_rs2_addr), .id_ex_rd_addr(id_ex_rd_addr),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_is_mdu(id_ex_is_mdu),
    .ex_mem_valid(ex_mem_valid), .ex_mem_rd_addr(ex_mem_rd_addr),
    .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_valid(mem_wb_valid),
    .mem_wb_rd_addr(mem_wb_rd_addr), .mem_wb_reg_write(mem_wb_reg_write),
    .mem_wb_mem_to_reg(mem_wb_mem_to_reg), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .mdu_done(mdu_done),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .bubble_mem(bubble_mem),
    .pc_sel_branch(pc_sel_branch), .mdu_start(mdu_start), .mdu_error(mdu_error),
    .stall_cycles(stall_cycles)
  );

  function automatic logic [8:0] ctrl_now();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
            bubble_mem, pc_sel_branch, mdu_start};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (ex_mem_valid && ex_mem_reg_write && ex_mem_rd_addr != 0 && ex_mem_rd_addr == rs) return 2'd1;
    if (mem_wb_valid && mem_wb_reg_write && mem_wb_rd_addr != 0 && mem_wb_rd_addr == rs)
      return mem_wb_mem_to_reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic predict();
    bit s_if, s_id, s_ex, s_mem, f_id, f_ex, bub, pcs, st;
    bit blocked, lu;
    {s_if, s_id, s_ex, s_mem, f_id, f_ex, bub, pcs, st} = '0;
    blocked = dmem_req && !dmem_ready;
    lu = id_ex_valid && id_ex_mem_read && id_ex_rd_addr != 0 &&
         ((id_uses_rs1 && id_ex_rd_addr == id_rs1_addr) || (id_uses_rs2 && id_ex_rd_addr == id_rs2_addr));
    if (m_memwait) begin
      if (!dmem_ready) {s_if, s_id, s_ex, s_mem} = 4'hF;
    end else if (m_mdu_elapsed >= 0) begin
      if (!mdu_done) {s_if, s_id, s_ex, bub} = 4'hF;
      s_mem = blocked;
    end else if (blocked) begin
      {s_if, s_id, s_ex, s_mem} = 4'hF;
    end else if (id_ex_valid && id_ex_is_mdu) begin
      {s_if, s_id, s_ex, bub, st} = 5'h1F;
    end else if (branch_taken && id_ex_valid) begin
      {pcs, f_id, f_ex} = 3'h7;
    end else if (lu) begin
      {s_if, s_id, f_ex} = 3'h7;
    end
    e_ctrl = {s_if, s_id, s_ex, s_mem, f_id, f_ex, bub, pcs, st};
    e_fa = fwd_model(id_ex_rs1_addr);
    e_fb = fwd_model(id_ex_rs2_addr);
  endtask

  task automatic model_edge();
    if (reset) begin
      m_memwait = 0; m_mdu_elapsed = -1; m_err = 0; m_cnt = 0;
    end else begin
      if (e_ctrl[8] && m_cnt < CMAX) m_cnt++;
      if (m_memwait) begin
        if (dmem_ready) m_memwait = 0;
      end else if (m_mdu_elapsed >= 0) begin
        if (mdu_done) m_mdu_elapsed = -1;
        else if (m_mdu_elapsed + 1 == MAXC) begin m_err = 1; m_mdu_elapsed = -1; end
        else m_mdu_elapsed++;
      end else if (dmem_req && !dmem_ready) begin
        m_memwait = 1;
      end else if (id_ex_valid && id_ex_is_mdu) begin
        m_mdu_elapsed = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    predict();
    check("forward_a", 32'(forward_a), 32'(e_fa));
    check("forward_b", 32'(forward_b), 32'(e_fb));
    check("ctrl", 32'(ctrl_now()), 32'(e_ctrl));
    check("mdu_error", 32'(mdu_error), 32'(m_err));
    check("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    {id_rs1_addr, id_rs2_addr, id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr} = '0;
    {ex_mem_rd_addr, mem_wb_rd_addr} = '0;
    {id_uses_rs1, id_uses_rs2, id_ex_valid, id_ex_mem_read, id_ex_is_mdu} = '0;
    {ex_mem_valid, ex_mem_reg_write, mem_wb_valid, mem_wb_reg_write, mem_wb_mem_to_reg} = '0;
    {branch_taken, dmem_req, dmem_ready, mdu_done} = '0;
  endtask

  task automatic random_inputs();
    id_rs1_addr = 5'($urandom_range(0, 3));    id_rs2_addr = 5'($urandom_range(0, 3));
    id_ex_rs1_addr = 5'($urandom_range(0, 3)); id_ex_rs2_addr = 5'($urandom_range(0, 3));
    id_ex_rd_addr = 5'($urandom_range(0, 3));  ex_mem_rd_addr = 5'($urandom_range(0, 3));
    mem_wb_rd_addr = 5'($urandom_range(0, 3));
    id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
    id_ex_valid = 1'($urandom); id_ex_mem_read = 1'($urandom);
    id_ex_is_mdu = ($urandom_range(0, 7) == 0);
    ex_mem_valid = 1'($urandom); ex_mem_reg_write = 1'($urandom);
    mem_wb_valid = 1'($urandom); mem_wb_reg_write = 1'($urandom); mem_wb_mem_to_reg = 1'($urandom);
    branch_taken = 1'($urandom); dmem_req = 1'($urandom); dmem_ready = 1'($urandom);
    mdu_done = ($urandom_range(0, 5) == 0);
    reset = ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    m_memwait = 0; m_mdu_elapsed = -1; m_err = 0; m_cnt = 0;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    reset = 1'b0;
    #1;
    check("reset_ctrl", 32'(ctrl_now()), 32'h0);
    check("reset_cnt", 32'(stall_cycles), 32'h0);
    check("reset_err", 32'(mdu_error), 32'h0);
    cycle();

    // Forwarding priority and rd=0 suppression
    ex_mem_valid = 1; ex_mem_reg_write = 1; ex_mem_rd_addr = 5;
    mem_wb_valid = 1; mem_wb_reg_write = 1; mem_wb_mem_to_reg = 1; mem_wb_rd_addr = 5;
    id_ex_rs1_addr = 5;
    #1 check("fwd_exmem_wins", 32'(forward_a), 32'd1);
    cycle();
    ex_mem_valid = 0;
    #1 check("fwd_wb_mem", 32'(forward_a), 32'd3);
    cycle();
    mem_wb_rd_addr = 0; id_ex_rs1_addr = 0;
    #1 check("fwd_rd0", 32'(forward_a), 32'd0);
    cycle();
    idle_inputs();

    // Load-use on rs2, then the bubble
    id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd_addr = 7; id_uses_rs2 = 1; id_rs2_addr = 7;
    #1 check("load_use", 32'(ctrl_now()), 32'b110001000);
    cycle();
    id_ex_valid = 0;
    #1 check("load_use_once", 32'(ctrl_now()), 32'h0);
    cycle();

    // Branch beats load-use
    id_ex_valid = 1; branch_taken = 1;
    #1 check("branch_over_lu", 32'(ctrl_now()), 32'b000011010);
    cycle();
    idle_inputs();

    // MDU op completing on the sixth cycle: five stall cycles in total
    reset = 1; cycle(); reset = 0;
    id_ex_valid = 1; id_ex_is_mdu = 1;
    #1 check("mdu_launch", 32'(ctrl_now()), 32'b111000101);
    cycle();
    for (int i = 0; i < 4; i++) begin
      #1 check("mdu_busy", 32'(ctrl_now()), 32'b111000100);
      cycle();
    end
    mdu_done = 1;
    #1 check("mdu_done_release", 32'(ctrl_now()), 32'h0);
    cycle();
    idle_inputs();
    #1 check("mdu_stall_cycles", 32'(stall_cycles), 32'd5);
    cycle();

    // MDU timeout
    id_ex_valid = 1; id_ex_is_mdu = 1;
    cycle();
    repeat (MAXC - 1) cycle();
    check("mdu_err_before", 32'(mdu_error), 32'd0);
    cycle();
    idle_inputs();
    #1 check("mdu_err_set", 32'(mdu_error), 32'd1);
    check("mdu_err_run", 32'(ctrl_now()), 32'h0);
    repeat (3) cycle();
    check("mdu_err_sticky", 32'(mdu_error), 32'd1);
    reset = 1; cycle(); reset = 0;
    #1 check("mdu_err_cleared", 32'(mdu_error), 32'd0);

    // Data-memory wait of three cycles
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("dmem_wait", 32'(ctrl_now()), 32'b111100000);
      cycle();
    end
    dmem_ready = 1;
    #1 check("dmem_ready", 32'(ctrl_now()), 32'h0);
    cycle();
    idle_inputs();

    // Reset in the middle of a memory wait
    dmem_req = 1;
    cycle();
    reset = 1;
    cycle();
    reset = 0; dmem_req = 0;
    #1 check("rst_mid_ctrl", 32'(ctrl_now()), 32'h0);
    check("rst_mid_cnt", 32'(stall_cycles), 32'h0);
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32 pipeline. It drives `forward_a`/`forward_b` into `ex_stage` and generates per-stage stall/flush for IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves load-use hazards, taken-branch flushes, multi-cycle MDU operations (start/done handshake) and data-memory wait states. It also keeps a saturating stall-cycle counter.

Parameters:
MDU_MAX_CYCLES, 64, cycles in MDU_BUSY without `mdu_done` before `mdu_error` is raised
CNT_WIDTH, 32, width of `stall_cycles` counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
id_rs1_addr  in  5  rs1 of instruction in IF/ID
id_rs2_addr  in  5  rs2 of instruction in IF/ID
id_uses_rs1  in  1  IF/ID instruction reads rs1
id_uses_rs2  in  1  IF/ID instruction reads rs2
id_ex_valid  in  1  ID/EX holds a real instruction
id_ex_rs1_addr  in  5  rs1 of EX instruction
id_ex_rs2_addr  in  5  rs2 of EX instruction
id_ex_rd_addr  in  5  rd of EX instruction
id_ex_mem_read  in  1  EX instruction is a load
id_ex_is_mdu  in  1  EX instruction is MUL/DIV/REM
ex_mem_valid  in  1  EX/MEM valid
ex_mem_rd_addr  in  5  EX/MEM rd
ex_mem_reg_write  in  1  EX/MEM writes rd
mem_wb_valid  in  1  MEM/WB valid
mem_wb_rd_addr  in  5  MEM/WB rd
mem_wb_reg_write  in  1  MEM/WB writes rd
mem_wb_mem_to_reg  in  1  MEM/WB result comes from memory
branch_taken  in  1  from ex_stage, same cycle
dmem_req  in  1  MEM stage issuing a data access
dmem_ready  in  1  data memory completes access this cycle
mdu_done  in  1  MDU result valid this cycle
forward_a  out  2  operand A select
forward_b  out  2  operand B select
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
stall_ex  out  1  hold ID/EX
stall_mem  out  1  hold EX/MEM
flush_id  out  1  clear IF/ID to bubble
flush_ex  out  1  load bubble into ID/EX
bubble_mem  out  1  load bubble into EX/MEM
pc_sel_branch  out  1  PC takes `branch_target`
mdu_start  out  1  one-cycle MDU launch pulse
mdu_error  out  1  sticky MDU timeout flag
stall_cycles  out  CNT_WIDTH  saturating count of cycles with `stall_if`=1

Behaviour:
- Forward encoding:
  - 00 = ID/EX register data
  - 01 = EX/MEM ALU result
  - 10 = MEM/WB ALU result
  - 11 = MEM/WB mem data
- Forwarding logic (combinational):
  - EX/MEM match (valid & reg_write & rd!=0 & rd==rsX) → 01.
  - Else MEM/WB match → 10, or 11 if `mem_wb_mem_to_reg`.
  - Else 00.
  - EX/MEM beats MEM/WB when both match.
- FSM states: RUN, MDU_BUSY, MEM_WAIT. Reset → RUN.
- Registered output reset values: `mdu_error`=0, `stall_cycles`=0, MDU counter=0.
- Combinational outputs are 0 whenever the state is RUN and no condition below holds.
- RUN, conditions in priority order:
  - **Memory stall:** `dmem_req` & !`dmem_ready` → `stall_if`/`id`/`ex`/`mem`=1; next state MEM_WAIT.
  - **MDU launch:** `id_ex_valid` & `id_ex_is_mdu` → `mdu_start`=1, `stall_if`/`id`/`ex`=1, `bubble_mem`=1; next state MDU_BUSY; MDU counter cleared.
  - **Taken branch:** `branch_taken` & `id_ex_valid` → `pc_sel_branch`=1, `flush_id`=1, `flush_ex`=1. Branch beats load-use in the same cycle.
  - **Load-use:** `id_ex_valid` & `id_ex_mem_read` & rd!=0 & ((`id_uses_rs1` & rd==`id_rs1_addr`) | (`id_uses_rs2` & rd==`id_rs2_addr`)) → `stall_if`=1, `stall_id`=1, `flush_ex`=1, for exactly one cycle.
- MEM_WAIT:
  - IF..MEM held (all four stalls=1).
  - Exits to RUN in the first cycle `dmem_ready`=1; all stalls are 0 in that cycle.
- MDU_BUSY:
  - `stall_if`/`id`/`ex`=1 and `bubble_mem`=1 every cycle; MDU counter increments.
  - On `mdu_done`: `stall_ex`=0, `bubble_mem`=0 so EX/MEM captures the result, `stall_if`/`id`=0; next state RUN.
  - If counter reaches MDU_MAX_CYCLES without `mdu_done`: set `mdu_error` (sticky until reset); next state RUN.
  - `dmem_req` & !`dmem_ready` in this state additionally asserts `stall_mem`; state is unchanged.
  - `mdu_start` is never asserted outside the RUN→MDU_BUSY edge.
- `stall_cycles`: +1 each cycle `stall_if`=1; saturates at all-ones.
- Reset mid-operation: returns to RUN next edge and clears all registered state; an in-flight MDU op is abandoned (no `mdu_start` reissue).

Decomposition:
- Add to `constants.v`:
  - `FWD_REG`/`FWD_EXMEM`/`FWD_WB_ALU`/`FWD_WB_MEM` encodings
  - `PCTRL_RUN`/`PCTRL_MDU_BUSY`/`PCTRL_MEM_WAIT` state codes
- One sub-module, `forward_unit`: the purely combinational operand-select logic, instantiated twice (A and B).

Test Plan:
- EX/MEM rd=5 reg_write, MEM/WB rd=5 mem_to_reg, `id_ex_rs1_addr`=5 → `forward_a`=01. Remove EX/MEM match → 11. rd=0 → 00.
- Load in EX rd=7, IF/ID uses rs2=7 → exactly one cycle of `stall_if`=`stall_id`=`flush_ex`=1, then all 0.
- Same load-use plus `branch_taken`=1 → `pc_sel_branch`=`flush_id`=`flush_ex`=1, `stall_if`=0.
- MDU op in EX, `mdu_done` after 5 cycles:
  - `mdu_start` pulses exactly once.
  - Stalls held for 5 cycles, released on the done cycle.
  - `stall_cycles` = 5.
- MDU op with no `mdu_done` and MDU_MAX_CYCLES=8 → `mdu_error`=1 after 8 cycles, state RUN; `mdu_error` stays 1 until reset.
- `dmem_req`=1, `dmem_ready` low for 3 cycles → all four stalls high for 3 cycles, 0 on the ready cycle. Assert `reset` in cycle 2 → outputs 0 and `stall_cycles`=0 next edge.
